// File: rtl/byte_lane_shift_pipe_if.sv
// -----------------------------------------------------------------------------
// byte_lane_shift_pipe_if
//   Handshake bundle for the lane shifter/rotator pipeline.
//
//   Parameters
//     WIDTH   number of lanes (power of two, >= 2)
//     ELEM_W  bits per lane
//
//   Signals (direction as seen by the shifter, i.e. the slave modport)
//     flush      in   squash everything in flight at the next edge
//     in_valid   in   operand valid
//     in_ready   out  operand can be accepted this cycle
//     in_data    in   operand, lane i = in_data[ELEM_W*i +: ELEM_W]
//     in_amt     in   shift/rotate amount in lanes
//     in_mode    in   00 rotr, 01 rotl, 10 shr zero-fill, 11 shl zero-fill
//     out_valid  out  result valid
//     out_ready  in   consumer accepts result
//     out_data   out  result
// -----------------------------------------------------------------------------
interface byte_lane_shift_pipe_if #(
   parameter int WIDTH  = 32,
   parameter int ELEM_W = 8
);
   localparam int AMT_W = $clog2(WIDTH);

   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH*ELEM_W-1:0]   in_data;
   logic [AMT_W-1:0]          in_amt;
   logic [1:0]                in_mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH*ELEM_W-1:0]   out_data;

   // Producer/consumer side.
   modport master (
      output flush, in_valid, in_data, in_amt, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Shifter side.
   modport slave (
      input  flush, in_valid, in_data, in_amt, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/byte_lane_shift_pipe.sv
// -----------------------------------------------------------------------------
// byte_lane_shift_pipe
//   Two-stage pipelined lane rotator/shifter. A vector of WIDTH lanes of
//   ELEM_W bits is rotated or zero-fill shifted right/left by in_amt lanes.
//   The shift network is log2(WIDTH) mux levels, one per amount bit, MSB
//   level first. Stage A registers the result of the upper ceil(AMT_W/2)
//   levels along with the leftover amount bits and the mode; stage B (the
//   output register) applies the remaining levels.
//
//   Ports
//     clk    in  clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of byte_lane_shift_pipe_if (operand/result
//            valid-ready handshakes and flush)
// -----------------------------------------------------------------------------
module byte_lane_shift_pipe #(
   parameter int WIDTH  = 32,
   parameter int ELEM_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   byte_lane_shift_pipe_if.slave  bus
);
   localparam int AMT_W = $clog2(WIDTH);
   localparam int DW    = WIDTH * ELEM_W;
   // Levels handled before the stage A register (rounded up) and after it.
   localparam int HI_N  = (AMT_W + 1) / 2;
   localparam int LO_N  = AMT_W - HI_N;
   localparam int LO_W  = (LO_N > 0) ? LO_N : 1;

   // One mux level: move every lane by s positions according to mode.
   // Because amt <= WIDTH-1, chaining zero-fill shifts by powers of two is
   // identical to one shift by the total amount, and rotations compose.
   function automatic logic [DW-1:0] lane_step(
      input logic [DW-1:0] d,
      input int            s,
      input logic [1:0]    mode
   );
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (mode)
            2'b00: r[ELEM_W*i +: ELEM_W] = d[ELEM_W*((i + s) % WIDTH) +: ELEM_W];
            2'b01: r[ELEM_W*i +: ELEM_W] = d[ELEM_W*((i - s + WIDTH) % WIDTH) +: ELEM_W];
            2'b10: if (i + s < WIDTH) r[ELEM_W*i +: ELEM_W] = d[ELEM_W*(i + s) +: ELEM_W];
            2'b11: if (i >= s)        r[ELEM_W*i +: ELEM_W] = d[ELEM_W*(i - s) +: ELEM_W];
            default: ;
         endcase
      end
      return r;
   endfunction

   // Stage A state.
   logic            a_valid_reg;
   logic [DW-1:0]   a_data_reg;
   logic [LO_W-1:0] a_amt_reg;
   logic [1:0]      a_mode_reg;

   // Stage B (output) state.
   logic            b_valid_reg;
   logic [DW-1:0]   b_data_reg;

   logic            a_adv;
   logic            b_adv;
   logic            a_load;
   logic            b_load;
   logic [DW-1:0]   a_data_next;
   logic [DW-1:0]   b_data_next;

   // Advance chain; in_ready therefore depends combinationally on out_ready.
   assign b_adv        = !b_valid_reg || bus.out_ready;
   assign a_adv        = !a_valid_reg || b_adv;
   assign bus.in_ready = a_adv && !bus.flush;
   assign a_load       = bus.in_valid && bus.in_ready;
   assign b_load       = a_valid_reg && b_adv;

   assign bus.out_valid = b_valid_reg;
   assign bus.out_data  = b_data_reg;

   // Upper amount bits, MSB level first.
   always_comb begin
      a_data_next = bus.in_data;
      for (int k = 0; k < HI_N; k++) begin
         if (bus.in_amt[AMT_W-1-k])
            a_data_next = lane_step(a_data_next, 1 << (AMT_W - 1 - k), bus.in_mode);
      end
   end

   // Remaining low amount bits, carried in a_amt_reg.
   always_comb begin
      b_data_next = a_data_reg;
      for (int k = 0; k < LO_N; k++) begin
         if (a_amt_reg[LO_N-1-k])
            b_data_next = lane_step(b_data_next, 1 << (LO_N - 1 - k), a_mode_reg);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_reg <= 1'b0;
         a_data_reg  <= '0;
         a_amt_reg   <= '0;
         a_mode_reg  <= 2'b00;
         b_valid_reg <= 1'b0;
         b_data_reg  <= '0;
      end else if (bus.flush) begin
         // Squash wins over every load; data registers keep stale contents.
         a_valid_reg <= 1'b0;
         b_valid_reg <= 1'b0;
      end else begin
         if (a_load) begin
            a_valid_reg <= 1'b1;
            a_data_reg  <= a_data_next;
            a_amt_reg   <= bus.in_amt[LO_W-1:0];
            a_mode_reg  <= bus.in_mode;
         end else if (b_adv) begin
            a_valid_reg <= 1'b0;
         end

         if (b_load) begin
            b_valid_reg <= 1'b1;
            b_data_reg  <= b_data_next;
         end else if (bus.out_ready) begin
            b_valid_reg <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_byte_lane_shift_pipe.sv
module tb_byte_lane_shift_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   byte_lane_shift_pipe_if #(.WIDTH(32), .ELEM_W(8)) bus32();
   byte_lane_shift_pipe_if #(.WIDTH(4),  .ELEM_W(8)) bus4();

   byte_lane_shift_pipe #(.WIDTH(32), .ELEM_W(8)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   byte_lane_shift_pipe #(.WIDTH(4), .ELEM_W(8)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   int vectors = 0;
   int miscompares = 0;
   int out_cnt = 0;
   logic [255:0] sb[$];

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %-20s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %-20s %0h", tag, got);
      end
   endtask

   // Reference straight from the lane formulas.
   function automatic logic [255:0] gold32(input logic [255:0] d, input int a, input logic [1:0] m);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         case (m)
            2'b00: r[8*i +: 8] = d[8*((i + a) % 32) +: 8];
            2'b01: r[8*i +: 8] = d[8*((i - a + 32) % 32) +: 8];
            2'b10: if (i + a < 32) r[8*i +: 8] = d[8*(i + a) +: 8];
            default: if (i >= a)   r[8*i +: 8] = d[8*(i - a) +: 8];
         endcase
      end
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic new_op32(input int a, input int m);
      bus32.in_valid = 1'b1;
      bus32.in_data  = rnd256();
      bus32.in_amt   = 5'(a);
      bus32.in_mode  = 2'(m);
   endtask

   // Scoreboard: inputs and outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (!rst_n || bus32.flush) begin
         sb.delete();
      end else begin
         if (bus32.out_valid && bus32.out_ready) begin
            out_cnt++;
            chk("sb_nonempty", 256'(sb.size() != 0), 256'd1);
            if (sb.size() != 0) chk("out_data", bus32.out_data, sb.pop_front());
         end
         if (bus32.in_valid && bus32.in_ready)
            sb.push_back(gold32(bus32.in_data, int'(bus32.in_amt), bus32.in_mode));
      end
   end

   task automatic run4(input logic [1:0] m, input logic [1:0] a, input logic [31:0] exp);
      string tag;
      tag = $sformatf("w4_m%0d_a%0d", m, a);
      cyc();
      bus4.in_valid  = 1'b1;
      bus4.in_data   = 32'h44332211;
      bus4.in_amt    = a;
      bus4.in_mode   = m;
      bus4.out_ready = 1'b1;
      #1 chk({tag, "_in_rdy"}, 256'(bus4.in_ready), 256'd1);
      cyc();
      bus4.in_valid = 1'b0;
      chk({tag, "_lat1"}, 256'(bus4.out_valid), 256'd0);
      cyc();
      chk({tag, "_valid"}, 256'(bus4.out_valid), 256'd1);
      chk(tag, 256'(bus4.out_data), 256'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] d;
      logic [255:0] held;
      int acc;
      int base;
      logic took;

      bus32.flush = 0; bus32.in_valid = 0; bus32.in_data = '0;
      bus32.in_amt = '0; bus32.in_mode = '0; bus32.out_ready = 0;
      bus4.flush = 0; bus4.in_valid = 0; bus4.in_data = '0;
      bus4.in_amt = '0; bus4.in_mode = '0; bus4.out_ready = 0;

      // Reset
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 256'(bus32.out_valid), 256'd0);
      chk("rst_out_data", bus32.out_data, 256'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      #1 chk("rst_in_ready", 256'(bus32.in_ready), 256'd1);

      // All modes at WIDTH=4
      run4(2'b00, 2'd1, 32'h11443322);
      run4(2'b01, 2'd1, 32'h33221144);
      run4(2'b10, 2'd1, 32'h00443322);
      run4(2'b11, 2'd1, 32'h33221100);
      run4(2'b00, 2'd0, 32'h44332211);
      run4(2'b01, 2'd0, 32'h44332211);
      run4(2'b10, 2'd0, 32'h44332211);
      run4(2'b11, 2'd0, 32'h44332211);
      run4(2'b10, 2'd3, 32'h00000044);
      run4(2'b11, 2'd3, 32'h11000000);
      run4(2'b00, 2'd3, 32'h33221144);

      // Rotate right by 5 at WIDTH=32, lane i = i
      for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
      cyc();
      bus32.in_valid = 1'b1; bus32.in_data = d; bus32.in_amt = 5'd5;
      bus32.in_mode = 2'b00; bus32.out_ready = 1'b1;
      #1 chk("rr_in_ready", 256'(bus32.in_ready), 256'd1);
      cyc();
      bus32.in_valid = 1'b0;
      chk("rr_lat1_valid", 256'(bus32.out_valid), 256'd0);
      cyc();
      chk("rr_valid", 256'(bus32.out_valid), 256'd1);
      chk("rr_lane0", 256'(bus32.out_data[7:0]), 256'h05);
      chk("rr_lane27", 256'(bus32.out_data[8*27 +: 8]), 256'h00);
      chk("rr_lane31", 256'(bus32.out_data[8*31 +: 8]), 256'h04);
      cyc();

      // Streaming: 64 back-to-back
      bus32.out_ready = 1'b1;
      for (int n = 0; n < 64; n++) begin
         cyc();
         new_op32(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
         #1 chk("stream_in_ready", 256'(bus32.in_ready), 256'd1);
         if (n >= 2) chk("stream_out_valid", 256'(bus32.out_valid), 256'd1);
      end
      cyc();
      bus32.in_valid = 1'b0;
      cyc(); cyc();
      chk("stream_drained", 256'(sb.size()), 256'd0);

      // Backpressure for 5 cycles, then pop-when-full
      cyc();
      bus32.out_ready = 1'b0;
      new_op32(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
      acc = 0;
      held = '0;
      for (int n = 0; n < 5; n++) begin
         #1;
         took = bus32.in_ready;
         if (took) acc++;
         if (n == 2) begin
            chk("bp_out_valid", 256'(bus32.out_valid), 256'd1);
            held = bus32.out_data;
         end
         if (n > 2) chk("bp_stable", bus32.out_data, held);
         cyc();
         if (took) new_op32(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
      end
      #1;
      chk("bp_accepted", 256'(acc), 256'd2);
      chk("bp_in_ready_low", 256'(bus32.in_ready), 256'd0);
      bus32.out_ready = 1'b1;
      #1;
      chk("pop_full_in_ready", 256'(bus32.in_ready), 256'd1);
      chk("pop_full_head", bus32.out_data, held);
      cyc();
      bus32.in_valid = 1'b0;
      cyc(); cyc(); cyc();
      chk("bp_drained", 256'(sb.size()), 256'd0);

      // Flush with 2 in flight plus a simultaneous operand
      bus32.out_ready = 1'b0;
      new_op32(3, 0);
      cyc();
      new_op32(7, 2);
      cyc();
      new_op32(9, 3);
      bus32.flush = 1'b1;
      bus32.out_ready = 1'b1;
      #1;
      chk("flush_in_ready", 256'(bus32.in_ready), 256'd0);
      base = out_cnt;
      cyc();
      bus32.flush = 1'b0;
      bus32.in_valid = 1'b0;
      #1;
      chk("flush_out_valid", 256'(bus32.out_valid), 256'd0);
      chk("flush_in_ready_after", 256'(bus32.in_ready), 256'd1);
      cyc(); cyc(); cyc();
      chk("flush_no_output", 256'(out_cnt - base), 256'd0);
      new_op32(13, 1);
      cyc();
      bus32.in_valid = 1'b0;
      cyc();
      chk("post_flush_valid", 256'(bus32.out_valid), 256'd1);
      cyc();
      chk("post_flush_done", 256'(out_cnt - base), 256'd1);

      // Async reset with pipeline full
      bus32.out_ready = 1'b0;
      new_op32(0, 0);
      bus32.in_data[7:0] = 8'hA5;
      cyc();
      new_op32(0, 1);
      bus32.in_data[7:0] = 8'h5A;
      cyc();
      bus32.in_valid = 1'b0;
      #1 chk("ar_full_valid", 256'(bus32.out_valid), 256'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 256'(bus32.out_valid), 256'd0);
      chk("ar_out_data", bus32.out_data, 256'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      #1;
      chk("ar_in_ready", 256'(bus32.in_ready), 256'd1);
      chk("ar_out_valid_rel", 256'(bus32.out_valid), 256'd0);
      bus32.out_ready = 1'b1;
      new_op32(31, 2);
      cyc();
      bus32.in_valid = 1'b0;
      chk("ar_lat1_valid", 256'(bus32.out_valid), 256'd0);
      cyc();
      chk("ar_fresh_valid", 256'(bus32.out_valid), 256'd1);
      cyc();
      chk("ar_drained", 256'(sb.size()), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
